// File: rtl/jacobi_pkg.sv
// Shared types and helpers for the Jacobi eigen-solver control blocks.
// Used by the sweep scheduler and the main controller.
package jacobi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_CONV,
    DONE
  } sched_state_t;

  typedef enum logic {
    MODE_CYCLIC,
    MODE_RR
  } sched_mode_t;

  function automatic logic [31:0] pair_addr(
    input logic [31:0] p,
    input logic [31:0] q,
    input logic [31:0] n
  );
    return p * n + q;
  endfunction

endpackage

// File: rtl/jacobi_sweep_scheduler_if.sv
// Controller/consumer side bundle of the Jacobi sweep scheduler.
// master = scheduler, slave = controller plus pair consumer.
interface jacobi_sweep_scheduler_if #(
  parameter int N              = 8,
  parameter int MEM_ADDR_WIDTH = 7,
  parameter int SWEEP_W        = 4
);
  localparam int IDX_W = $clog2(N);

  logic                      start_i;
  logic                      mode_i;
  logic [SWEEP_W-1:0]        sweeps_i;
  logic                      abort_i;
  logic                      conv_vld_i;
  logic                      conv_i;
  logic                      pair_vld_o;
  logic                      pair_rdy_i;
  logic [IDX_W-1:0]          pair_p_o;
  logic [IDX_W-1:0]          pair_q_o;
  logic [MEM_ADDR_WIDTH-1:0] addr_pp_o;
  logic [MEM_ADDR_WIDTH-1:0] addr_qq_o;
  logic [MEM_ADDR_WIDTH-1:0] addr_pq_o;
  logic                      pair_last_o;
  logic                      round_last_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      converged_o;
  logic [SWEEP_W-1:0]        sweeps_used_o;

  modport master (
    input  start_i, mode_i, sweeps_i, abort_i,
    input  conv_vld_i, conv_i, pair_rdy_i,
    output pair_vld_o, pair_p_o, pair_q_o,
    output addr_pp_o, addr_qq_o, addr_pq_o,
    output pair_last_o, round_last_o,
    output busy_o, done_o, converged_o, sweeps_used_o
  );

  modport slave (
    output start_i, mode_i, sweeps_i, abort_i,
    output conv_vld_i, conv_i, pair_rdy_i,
    input  pair_vld_o, pair_p_o, pair_q_o,
    input  addr_pp_o, addr_qq_o, addr_pq_o,
    input  pair_last_o, round_last_o,
    input  busy_o, done_o, converged_o, sweeps_used_o
  );

endinterface

// File: rtl/jacobi_pair_gen.sv
// Rotation pair generator: cyclic-by-row and round-robin orderings.
// Outputs are registered; nxt_p/nxt_q expose the value being loaded.
module jacobi_pair_gen
  import jacobi_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             advance,
  input  sched_mode_t      mode,
  output logic [IDX_W-1:0] p,
  output logic [IDX_W-1:0] q,
  output logic             last,
  output logic             round_last,
  output logic [IDX_W-1:0] nxt_p,
  output logic [IDX_W-1:0] nxt_q
);

  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N / 2 - 1);
  localparam logic [IDX_W-1:0] R_LAST = IDX_W'(N - 2);

  logic [IDX_W-1:0] pos_q [N];
  logic [IDX_W-1:0] pos_d [N];
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] rnd_q, rnd_d;
  logic [IDX_W-1:0] p_d, q_d, a, b;
  logic             last_d, rl_d;
  logic             ld;
  sched_mode_t      mode_q, mode_d;

  assign ld    = restart | advance;
  assign nxt_p = p_d;
  assign nxt_q = q_d;

  always_comb begin
    pos_d  = pos_q;
    k_d    = k_q;
    rnd_d  = rnd_q;
    mode_d = mode_q;
    p_d    = p;
    q_d    = q;
    if (restart) begin
      for (int i = 0; i < N; i++)
        pos_d[i] = IDX_W'(i);
      k_d    = '0;
      rnd_d  = '0;
      mode_d = mode;
      p_d    = '0;
      q_d    = IDX_W'(1);
    end else if (advance) begin
      if (mode_q == MODE_RR) begin
        if (k_q == K_LAST) begin
          k_d      = '0;
          rnd_d    = rnd_q + 1'b1;
          pos_d[1] = pos_q[N-1];
          for (int i = 2; i < N; i++)
            pos_d[i] = pos_q[i-1];
        end else begin
          k_d = k_q + 1'b1;
        end
      end else if (q == I_LAST) begin
        p_d = p + 1'b1;
        q_d = p + 2'd2;
      end else begin
        q_d = q + 1'b1;
      end
    end
    a = pos_d[k_d];
    b = pos_d[I_LAST - k_d];
    if (mode_d == MODE_RR) begin
      p_d    = (a < b) ? a : b;
      q_d    = (a < b) ? b : a;
      rl_d   = (k_d == K_LAST);
      last_d = rl_d && (rnd_d == R_LAST);
    end else begin
      last_d = (p_d == R_LAST);
      rl_d   = last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        pos_q[i] <= IDX_W'(i);
      k_q        <= '0;
      rnd_q      <= '0;
      mode_q     <= MODE_CYCLIC;
      p          <= '0;
      q          <= '0;
      last       <= 1'b0;
      round_last <= 1'b0;
    end else if (ld) begin
      pos_q      <= pos_d;
      k_q        <= k_d;
      rnd_q      <= rnd_d;
      mode_q     <= mode_d;
      p          <= p_d;
      q          <= q_d;
      last       <= last_d;
      round_last <= rl_d;
    end
  end

endmodule

// File: rtl/jacobi_sweep_scheduler.sv
// Jacobi sweep sequencer: FSM, sweep counting, RAM address generation.
// Pair ordering itself lives in jacobi_pair_gen.
module jacobi_sweep_scheduler
  import jacobi_pkg::*;
#(
  parameter int N              = 8,
  parameter int MEM_ADDR_WIDTH = 7,
  parameter int SWEEP_W        = 4
) (
  input logic clk,
  input logic rst,
  jacobi_sweep_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(N);

  sched_state_t       state_q, state_d;
  sched_mode_t        mode_q, gen_mode;
  logic [SWEEP_W-1:0] max_q, used_q;
  logic               restart, advance, fire;
  logic               accept;
  logic [IDX_W-1:0]   nxt_p, nxt_q;

  jacobi_pair_gen #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_gen (
    .clk        (clk),
    .rst_n      (rst),
    .restart    (restart),
    .advance    (advance),
    .mode       (gen_mode),
    .p          (bus.pair_p_o),
    .q          (bus.pair_q_o),
    .last       (bus.pair_last_o),
    .round_last (bus.round_last_o),
    .nxt_p      (nxt_p),
    .nxt_q      (nxt_q)
  );

  assign fire   = bus.pair_vld_o & bus.pair_rdy_i;
  assign accept = (state_q == IDLE) & bus.start_i & ~bus.abort_i;

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    advance  = 1'b0;
    gen_mode = mode_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d  = ISSUE;
          restart  = 1'b1;
          gen_mode = sched_mode_t'(bus.mode_i);
        end
      end
      ISSUE: begin
        if (fire) begin
          if (bus.pair_last_o) state_d = WAIT_CONV;
          else                 advance = 1'b1;
        end
      end
      WAIT_CONV: begin
        // used_q already counts the sweep just finished
        if (bus.conv_vld_i) begin
          if (!bus.conv_i && used_q < max_q) begin
            state_d = ISSUE;
            restart = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort_i) begin
      state_d = IDLE;
      restart = 1'b0;
      advance = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      mode_q            <= MODE_CYCLIC;
      max_q             <= '0;
      used_q            <= '0;
      bus.pair_vld_o    <= 1'b0;
      bus.busy_o        <= 1'b0;
      bus.done_o        <= 1'b0;
      bus.converged_o   <= 1'b0;
      bus.sweeps_used_o <= '0;
      bus.addr_pp_o     <= '0;
      bus.addr_qq_o     <= '0;
      bus.addr_pq_o     <= '0;
    end else begin
      state_q        <= state_d;
      bus.pair_vld_o <= (state_d == ISSUE);
      bus.busy_o     <= (state_d == ISSUE) || (state_d == WAIT_CONV);
      bus.done_o     <= (state_d == DONE);
      if (accept) begin
        mode_q            <= sched_mode_t'(bus.mode_i);
        max_q             <= (bus.sweeps_i == '0) ? SWEEP_W'(1) : bus.sweeps_i;
        used_q            <= '0;
        bus.converged_o   <= 1'b0;
        bus.sweeps_used_o <= '0;
      end
      if (state_q == ISSUE && state_d == WAIT_CONV)
        used_q <= used_q + 1'b1;
      if (state_q == WAIT_CONV && state_d == DONE) begin
        bus.converged_o   <= bus.conv_i;
        bus.sweeps_used_o <= used_q;
      end
      if (restart | advance) begin
        bus.addr_pp_o <= MEM_ADDR_WIDTH'(pair_addr(32'(nxt_p), 32'(nxt_p), N));
        bus.addr_qq_o <= MEM_ADDR_WIDTH'(pair_addr(32'(nxt_q), 32'(nxt_q), N));
        bus.addr_pq_o <= MEM_ADDR_WIDTH'(pair_addr(32'(nxt_p), 32'(nxt_q), N));
      end
    end
  end

endmodule

// File: tb/tb_jacobi_sweep_scheduler.sv
// Bench for jacobi_sweep_scheduler at N=4: scoreboard of expected pairs,
// directed sweeps, backpressure, abort and mid-sweep reset.
module tb_jacobi_sweep_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  jacobi_sweep_scheduler_if #(
    .N(4), .MEM_ADDR_WIDTH(4), .SWEEP_W(4)
  ) bus ();

  jacobi_sweep_scheduler #(
    .N(4), .MEM_ADDR_WIDTH(4), .SWEEP_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_xfer = 0;

  logic [17:0] exp_q [$];

  int cyc_p [6] = '{0, 0, 0, 1, 1, 2};
  int cyc_q [6] = '{1, 2, 3, 2, 3, 3};
  int rr_p  [6] = '{0, 1, 0, 1, 0, 2};
  int rr_q  [6] = '{3, 2, 2, 3, 1, 3};
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pairs(input bit rr, input int n);
    int  p, q;
    bit  last, rl;
    for (int i = 0; i < n; i++) begin
      p    = rr ? rr_p[i] : cyc_p[i];
      q    = rr ? rr_q[i] : cyc_q[i];
      last = (i == 5);
      rl   = rr ? (i % 2 == 1) : last;
      exp_q.push_back({2'(p), 2'(q), 4'(p * 5), 4'(q * 5),
                       4'(p * 4 + q), last, rl});
    end
  endtask

  // Pair scoreboard and stall-stability monitor.
  logic [17:0] obs_w, prev_w;
  logic        prev_stall = 1'b0;

  assign obs_w = {bus.pair_p_o, bus.pair_q_o, bus.addr_pp_o,
                  bus.addr_qq_o, bus.addr_pq_o, bus.pair_last_o,
                  bus.round_last_o};

  always @(negedge clk) begin
    if (rst && bus.pair_vld_o) begin
      if (prev_stall)
        chk("stall_stable", 32'(obs_w), 32'(prev_w));
      if (bus.pair_rdy_i) begin
        n_xfer++;
        if (exp_q.size() == 0)
          chk("unexpected_pair", 32'(obs_w), 32'h3ffff);
        else
          chk("pair", 32'(obs_w), 32'(exp_q.pop_front()));
      end
    end
    prev_stall <= rst && bus.pair_vld_o && !bus.pair_rdy_i;
    prev_w     <= obs_w;
  end

  task automatic run_sweep(input bit rr, input int sweeps, input bit conv,
                           input bit bp, input int exp_used,
                           input bit exp_conv, input string tag);
    bit seen;
    for (int s = 0; s < exp_used; s++)
      push_pairs(rr, 6);
    n_xfer         = 0;
    bus.conv_i     = conv;
    bus.conv_vld_i = 1'b1;
    bus.pair_rdy_i = 1'b1;
    bus.mode_i     = rr;
    bus.sweeps_i   = 4'(sweeps);
    bus.start_i    = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    chk({tag, "_lat_vld"}, 32'(bus.pair_vld_o), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bp) bus.pair_rdy_i = (c < 4) ? bp_pat[c] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
    end
    bus.pair_rdy_i = 1'b1;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_converged"}, 32'(bus.converged_o), 32'(exp_conv));
    chk({tag, "_sweeps_used"}, 32'(bus.sweeps_used_o), 32'(exp_used));
    chk({tag, "_n_pairs"}, 32'(n_xfer), 32'(6 * exp_used));
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_conv_hold"}, 32'(bus.converged_o), 32'(exp_conv));
    exp_q.delete();
  endtask

  initial begin
    bit done_seen;
    bus.start_i    = 1'b0;
    bus.mode_i     = 1'b0;
    bus.sweeps_i   = '0;
    bus.abort_i    = 1'b0;
    bus.conv_vld_i = 1'b0;
    bus.conv_i     = 1'b0;
    bus.pair_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(bus.pair_vld_o), 32'd0);
    chk("rst_status", 32'({bus.busy_o, bus.done_o, bus.converged_o,
                           bus.sweeps_used_o}), 32'd0);
    chk("rst_pair", 32'(obs_w), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_sweep(1'b0, 1, 1'b0, 1'b0, 1, 1'b0, "cyc1");
    run_sweep(1'b1, 1, 1'b0, 1'b0, 1, 1'b0, "rr1");
    run_sweep(1'b0, 1, 1'b0, 1'b1, 1, 1'b0, "cyc_bp");
    run_sweep(1'b1, 1, 1'b0, 1'b1, 1, 1'b0, "rr_bp");
    run_sweep(1'b0, 4, 1'b1, 1'b0, 1, 1'b1, "conv_early");
    run_sweep(1'b0, 2, 1'b0, 1'b0, 2, 1'b0, "two_sweeps");
    run_sweep(1'b1, 2, 1'b0, 1'b1, 2, 1'b0, "rr_two_bp");
    run_sweep(1'b0, 0, 1'b0, 1'b0, 1, 1'b0, "zero_sweeps");

    // abort on the 3rd pair, with start asserted while busy
    push_pairs(1'b0, 3);
    n_xfer         = 0;
    bus.conv_i     = 1'b0;
    bus.mode_i     = 1'b0;
    bus.sweeps_i   = 4'd1;
    bus.start_i    = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    chk("abort_vld", 32'(bus.pair_vld_o), 32'd0);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done_o || bus.pair_vld_o) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_n_pairs", 32'(n_xfer), 32'd3);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_sweep(1'b0, 1, 1'b0, 1'b0, 1, 1'b0, "after_abort");

    // asynchronous reset in the middle of a round-robin sweep
    push_pairs(1'b1, 2);
    n_xfer       = 0;
    bus.mode_i   = 1'b1;
    bus.sweeps_i = 4'd3;
    bus.start_i  = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_vld", 32'(bus.pair_vld_o), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done_o || bus.pair_vld_o) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_mid_quiet", 32'(done_seen), 32'd0);
    chk("rst_mid_n_pairs", 32'(n_xfer), 32'd2);
    exp_q.delete();
    run_sweep(1'b0, 1, 1'b0, 1'b0, 1, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
